// File: rtl/uart_massiv_pkg.sv
// Shared definitions for the UART massiv receive path: parity encodings,
// receive FSM states, bit-period helper and idle-timeout length.
package uart_massiv_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Idle time, in bit periods, that ends a burst when the timeout is built in
    localparam int unsigned IDLE_TIMEOUT_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_STORE
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_pack_deserializer.sv
// Serial-to-pack front end: 2-FF line synchroniser, receive FSM and bit timer.
// Emits a one-clock pack_valid with the pack data and a combined parity/framing
// error flag. With UART_RX_IDLE_TIMEOUT_EN defined it also exposes the
// synchronised falling-edge strobe used by the burst-end timeout.
module uart_rx_pack_deserializer
    import uart_massiv_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 4,
    parameter int unsigned PARITY        = PARITY_EVEN,
    parameter int unsigned NUM_DATA_BITS = 5,
    parameter int unsigned NUM_STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     pack_valid,
    output logic [NUM_DATA_BITS-1:0] pack_data,
    output logic                     pack_err,
    output logic                     active
`ifdef UART_RX_IDLE_TIMEOUT_EN
    ,
    output logic                     rx_fall_c
`endif
);

    localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W  = $clog2(NUM_DATA_BITS + 1);
    localparam int unsigned STOP_W = 2;

    logic                     rx_meta;
    logic                     rx_sync;
    logic                     rx_prev;
    logic                     fall_c;
    logic                     bit_end_c;
    logic                     par_exp_c;
    rx_state_t                state;
    logic [TMR_W-1:0]         timer;
    logic [BIT_W-1:0]         bit_idx;
    logic [STOP_W-1:0]        stop_idx;
    logic [NUM_DATA_BITS-1:0] shreg;
    logic                     perr;
    logic                     ferr;

    assign fall_c    = rx_prev & ~rx_sync;
    assign bit_end_c = (timer == TMR_W'(CLKS_PER_BIT - 1));
    assign par_exp_c = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);

`ifdef UART_RX_IDLE_TIMEOUT_EN
    assign rx_fall_c = fall_c;
`endif

    // Synchronise the asynchronous line and keep one delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive FSM; the start check lands half a bit after the detected edge,
    // every later sample one full bit period after the previous one
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            stop_idx   <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            pack_valid <= 1'b0;
            pack_data  <= '0;
            pack_err   <= 1'b0;
            active     <= 1'b0;
        end else begin
            pack_valid <= 1'b0;
            timer      <= timer + TMR_W'(1);
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (fall_c) begin
                        state    <= ST_START;
                        active   <= 1'b1;
                        bit_idx  <= '0;
                        stop_idx <= '0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (timer == TMR_W'(CLKS_PER_BIT / 2 - 1)) begin
                        timer <= '0;
                        if (!rx_sync) begin
                            state <= ST_DATA;
                        end else begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        timer <= '0;
                        shreg <= {rx_sync, shreg[NUM_DATA_BITS-1:1]};
                        if (bit_idx == BIT_W'(NUM_DATA_BITS - 1)) begin
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_c) begin
                        timer <= '0;
                        perr  <= (rx_sync != par_exp_c);
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end_c) begin
                        timer <= '0;
                        ferr  <= ferr | ~rx_sync;
                        if (stop_idx == STOP_W'(NUM_STOP_BITS - 1)) begin
                            state      <= ST_STORE;
                            pack_valid <= 1'b1;
                            pack_data  <= shreg;
                            pack_err   <= perr | ferr | ~rx_sync;
                        end else begin
                            stop_idx <= stop_idx + STOP_W'(1);
                        end
                    end
                end
                ST_STORE: begin
                    timer  <= '0;
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_massiv_receiver.sv
// UART massiv receiver: collects received packs into a flat array and reports
// pack count, error count, overflow and FSM activity.
// Optional feature macro: UART_RX_IDLE_TIMEOUT_EN adds OUT_RX_BURST_END, a
// one-clock pulse after a stored burst is followed by a quiet line.
module uart_rx_massiv_receiver
    import uart_massiv_pkg::*;
#(
    parameter int unsigned UART_BAUD_RATE           = 9600,
    parameter int unsigned CLOCK_FREQUENCY          = 38400,
    parameter int unsigned PARITY                   = PARITY_EVEN,
    parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 5,
    parameter int unsigned NUMBER_STOP_BITS         = 1,
    parameter int unsigned RX_MASSIV_DEEP           = 4,
    parameter int unsigned RX_MASSIV_DEEP_LOG_2     = $clog2(RX_MASSIV_DEEP)
) (
    input  logic                                                IN_CLOCK,
    input  logic                                                IN_RESET,
    input  logic                                                RX_PORT,
    input  logic                                                IN_RX_CLEAR_BUFFER,
    output logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0]  OUT_RX_DATA_MASSIV,
    output logic [RX_MASSIV_DEEP_LOG_2:0]                       OUT_RX_NUM_OF_DATA_PACKS_READY,
    output logic [RX_MASSIV_DEEP_LOG_2:0]                       OUT_RX_ERROR,
    output logic                                                OUT_RX_OVERFLOW,
    output logic                                                OUT_RX_ACTIVE
`ifdef UART_RX_IDLE_TIMEOUT_EN
    ,
    output logic                                                OUT_RX_BURST_END
`endif
);

    localparam int unsigned N     = NUM_OF_DATA_BITS_IN_PACK;
    localparam int unsigned D     = RX_MASSIV_DEEP;
    localparam int unsigned CNT_W = RX_MASSIV_DEEP_LOG_2 + 1;
    localparam int unsigned CPB   = clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);

    logic         pack_valid;
    logic [N-1:0] pack_data;
    logic         pack_err;
    logic         store_ok_c;

`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int unsigned TIMEOUT = IDLE_TIMEOUT_BITS * CPB;
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

    logic            rx_fall_c;
    logic            armed;
    logic [TO_W-1:0] idle_cnt;
`endif

    uart_rx_pack_deserializer #(
        .CLKS_PER_BIT  (CPB),
        .PARITY        (PARITY),
        .NUM_DATA_BITS (N),
        .NUM_STOP_BITS (NUMBER_STOP_BITS)
    ) u_deser (
        .clk        (IN_CLOCK),
        .rst        (IN_RESET),
        .rx         (RX_PORT),
        .pack_valid (pack_valid),
        .pack_data  (pack_data),
        .pack_err   (pack_err),
        .active     (OUT_RX_ACTIVE)
`ifdef UART_RX_IDLE_TIMEOUT_EN
        ,
        .rx_fall_c  (rx_fall_c)
`endif
    );

    assign store_ok_c = pack_valid && (OUT_RX_NUM_OF_DATA_PACKS_READY < CNT_W'(D));

    // Pack array and counters; clear wins over a pack finishing in the same cycle
    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET || IN_RX_CLEAR_BUFFER) begin
            OUT_RX_DATA_MASSIV             <= '0;
            OUT_RX_NUM_OF_DATA_PACKS_READY <= '0;
            OUT_RX_ERROR                   <= '0;
            OUT_RX_OVERFLOW                <= 1'b0;
        end else if (pack_valid) begin
            if (store_ok_c) begin
                for (int k = 0; k < D; k++) begin
                    if (OUT_RX_NUM_OF_DATA_PACKS_READY == CNT_W'(k)) begin
                        OUT_RX_DATA_MASSIV[k*N +: N] <= pack_data;
                    end
                end
                OUT_RX_NUM_OF_DATA_PACKS_READY <= OUT_RX_NUM_OF_DATA_PACKS_READY + CNT_W'(1);
                if (pack_err && (OUT_RX_ERROR < CNT_W'(D))) begin
                    OUT_RX_ERROR <= OUT_RX_ERROR + CNT_W'(1);
                end
            end else begin
                OUT_RX_OVERFLOW <= 1'b1;
            end
        end
    end

`ifdef UART_RX_IDLE_TIMEOUT_EN
    // Burst-end timer: counts quiet clocks from the last stop mid-sample and
    // fires once if a pack was stored since the last clear or pulse
    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            idle_cnt         <= '0;
            armed            <= 1'b0;
            OUT_RX_BURST_END <= 1'b0;
        end else begin
            OUT_RX_BURST_END <= 1'b0;
            if (IN_RX_CLEAR_BUFFER) begin
                idle_cnt <= '0;
                armed    <= 1'b0;
            end else if (pack_valid) begin
                idle_cnt <= TO_W'(1);
                if (store_ok_c) begin
                    armed <= 1'b1;
                end
            end else if (OUT_RX_ACTIVE || rx_fall_c) begin
                idle_cnt <= '0;
            end else if (armed) begin
                if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    OUT_RX_BURST_END <= 1'b1;
                    armed            <= 1'b0;
                    idle_cnt         <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TO_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_massiv_receiver.sv
// Bench for uart_rx_massiv_receiver: 4 clk/bit, 5 data bits, even parity,
// 1 stop bit, depth 4. A frame-level model predicts every output each cycle.
module tb_uart_rx_massiv_receiver;

    localparam int N   = 5;
    localparam int D   = 4;
    localparam int CPB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx  = 1'b1;
    logic           clr = 1'b0;
    logic [N*D-1:0] data;
    logic [2:0]     ready;
    logic [2:0]     errc;
    logic           ovf;
    logic           act;
`ifdef UART_RX_IDLE_TIMEOUT_EN
    logic           burst;
`endif

    always #5 clk = ~clk;

    uart_rx_massiv_receiver #(
        .UART_BAUD_RATE           (9600),
        .CLOCK_FREQUENCY          (38400),
        .PARITY                   (2),
        .NUM_OF_DATA_BITS_IN_PACK (N),
        .NUMBER_STOP_BITS         (1),
        .RX_MASSIV_DEEP           (D),
        .RX_MASSIV_DEEP_LOG_2     (2)
    ) dut (
        .IN_CLOCK                       (clk),
        .IN_RESET                       (rst),
        .RX_PORT                        (rx),
        .IN_RX_CLEAR_BUFFER             (clr),
        .OUT_RX_DATA_MASSIV             (data),
        .OUT_RX_NUM_OF_DATA_PACKS_READY (ready),
        .OUT_RX_ERROR                   (errc),
        .OUT_RX_OVERFLOW                (ovf),
        .OUT_RX_ACTIVE                  (act)
`ifdef UART_RX_IDLE_TIMEOUT_EN
        ,
        .OUT_RX_BURST_END               (burst)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model state: stored packs, error count, overflow, activity, burst timer
    logic [N-1:0] m_q[$];
    int           m_err   = 0;
    bit           m_ovf   = 1'b0;
    bit           m_act   = 1'b0;
    bit           m_armed = 1'b0;
    int           m_idle  = 0;
    bit           chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N*D-1:0] m_flat();
        logic [N*D-1:0] f;
        f = '0;
        foreach (m_q[i]) f[i*N +: N] = m_q[i];
        return f;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_err   = 0;
        m_ovf   = 1'b0;
        m_armed = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_act = 1'b0;
    endfunction

    function automatic void model_frame_end(input logic [N-1:0] d, input bit e);
        m_idle = 1;
        if (m_q.size() < D) begin
            m_q.push_back(d);
            if (e) m_err++;
            m_armed = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_massiv", 32'(data), 32'(m_flat()));
            check("packs_ready", 32'(ready), 32'(m_q.size()));
            check("rx_error", 32'(errc), 32'(m_err));
            check("overflow", 32'(ovf), 32'(m_ovf));
            check("active", 32'(act), 32'(m_act));
`ifdef UART_RX_IDLE_TIMEOUT_EN
            check("burst_end", 32'(burst), 32'(m_armed && (m_idle == 40)));
            if (m_armed && (m_idle == 40)) m_armed = 1'b0;
`endif
            m_idle++;
        end
    end

    // One frame: start, 5 data LSB first, parity, stop; optional clear on the store edge
    task automatic send_frame(input logic [N-1:0] d, input logic par, input logic stop,
                              input bit clr_at_store);
        logic [7:0] bits;
        int e;
        bits = {stop, par, d, 1'b0};
        e = 0;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) rx = bits[i];
                @(posedge clk);
                e++;
                if (e == 3) m_act = 1'b1;
            end
        end
        @(negedge clk);
        rx = 1'b1;
        @(posedge clk);             // stop-bit mid-sample edge
        @(negedge clk);
        if (clr_at_store) clr = 1'b1;
        @(posedge clk);             // pack lands one clock later
        m_act = 1'b0;
        if (clr_at_store) model_clear();
        else model_frame_end(d, (par != ^d) || !stop);
        if (clr_at_store) begin
            @(negedge clk);
            clr = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clr = 1'b0;
    endtask

    // One-clock low pulse: seen as an edge, rejected at the half-bit check
    task automatic glitch();
        @(negedge clk);
        rx = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rx = 1'b1;
        @(posedge clk);
        @(posedge clk);
        m_act = 1'b1;
        @(posedge clk);
        @(posedge clk);
        m_act = 1'b0;
    endtask

    // Start bit plus two data bits, then reset while the FSM is in DATA
    task automatic reset_mid_frame();
        logic [2:0] bits;
        int e;
        bits = 3'b010;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) rx = bits[i];
                @(posedge clk);
                e++;
                if (e == 3) m_act = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hits;
        int first_n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Two good packs
        send_frame(5'b01010, 1'b0, 1'b1, 1'b0);
        send_frame(5'b10011, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_data", 32'(data[9:0]), 32'(10'b1001101010));
        check("t1_ready", 32'(ready), 32'd2);
        check("t1_err", 32'(errc), 32'd0);
        do_clear();

        // Parity error, then framing error
        send_frame(5'b00111, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t2_ready", 32'(ready), 32'd1);
        check("t2_err", 32'(errc), 32'd1);
        check("t2_slot0", 32'(data[4:0]), 32'(5'b00111));
        send_frame(5'b10101, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_ferr", 32'(errc), 32'd2);
        check("t2_slot1", 32'(data[9:5]), 32'(5'b10101));
        do_clear();

        // Fill past depth
        send_frame(5'b00001, 1'b1, 1'b1, 1'b0);
        send_frame(5'b00010, 1'b1, 1'b1, 1'b0);
        send_frame(5'b00100, 1'b1, 1'b1, 1'b0);
        send_frame(5'b01000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_full_no_ovf", 32'(ovf), 32'd0);
        send_frame(5'b10000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_ready", 32'(ready), 32'd4);
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_data", 32'(data), 32'(20'b01000001000001000001));
        do_clear();
        check("t3_clr_data", 32'(data), 32'd0);
        check("t3_clr_ready", 32'(ready), 32'd0);
        check("t3_clr_ovf", 32'(ovf), 32'd0);

        // False start
        glitch();
        repeat (8) @(negedge clk);
        check("t4_ready", 32'(ready), 32'd0);
        check("t4_active", 32'(act), 32'd0);

        // Reset mid-frame, then a clean pack
        reset_mid_frame();
        @(negedge clk);
        check("t5_active", 32'(act), 32'd0);
        check("t5_ready0", 32'(ready), 32'd0);
        repeat (3) @(negedge clk);
        send_frame(5'b11100, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_ready", 32'(ready), 32'd1);
        check("t5_slot0", 32'(data[4:0]), 32'(5'b11100));

        // Clear on the store edge discards that pack
        do_clear();
        send_frame(5'b00011, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("t7_discard", 32'(ready), 32'd0);
        send_frame(5'b11111, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t7_after", 32'(ready), 32'd1);
        check("t7_slot0", 32'(data[4:0]), 32'(5'b11111));

`ifdef UART_RX_IDLE_TIMEOUT_EN
        // Burst end 40 clocks after the stop mid-sample
        do_clear();
        send_frame(5'b00101, 1'b0, 1'b1, 1'b0);
        hits    = 0;
        first_n = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (burst === 1'b1) begin
                hits++;
                if (first_n == 0) first_n = n;
            end
        end
        check("t6_pulse_pos", 32'(first_n), 32'd40);
        check("t6_pulse_cnt", 32'(hits), 32'd1);
`else
        hits    = 0;
        first_n = 0;
`endif

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
